// File: rtl/data_ack_cross_domain.sv
// ---------------------------------------------------------------------------
// data_ack_cross_domain
//
// Moves one WIDTH-bit word at a time from the clkA domain to the clkB domain
// using a request toggle (A->B) and an acknowledge toggle (B->A). Only the two
// 1-bit toggles pass through synchronizers; the multi-bit hold register is
// sampled by clkB only after the request toggle has been synchronized, so it
// is guaranteed stable when it is captured.
//
// Ports:
//   clkA, rstA        source clock and asynchronous active-high reset
//   clkB, rstB        destination clock and asynchronous active-high reset
//   in_data_clkA      word offered by the clkA producer
//   in_valid_clkA     producer has a word on in_data_clkA
//   in_ready_clkA     block accepts a word on this clkA edge (IDLE)
//   busy_clkA         a word is in flight (~in_ready_clkA)
//   out_data_clkB     delivered word, holds its value after acceptance
//   out_valid_clkB    out_data_clkB is valid
//   out_ready_clkB    clkB consumer accepts the word
// ---------------------------------------------------------------------------
module data_ack_cross_domain #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic             clkA,
    input  logic             rstA,
    input  logic             clkB,
    input  logic             rstB,
    input  logic [WIDTH-1:0] in_data_clkA,
    input  logic             in_valid_clkA,
    output logic             in_ready_clkA,
    output logic             busy_clkA,
    output logic [WIDTH-1:0] out_data_clkB,
    output logic             out_valid_clkB,
    input  logic             out_ready_clkB
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_ACK = 1'b1;

    // A-domain state
    logic [0:0]             state_q, state_d;
    logic                   reqToggle_q, reqToggle_d;
    logic [WIDTH-1:0]       holdData_q, holdData_d;
    logic [SYNC_STAGES-1:0] ackSync_q;
    logic                   ackSynced;

    // B-domain state
    logic [SYNC_STAGES-1:0] reqSync_q;
    logic                   reqEdge_q;
    logic                   reqDetect;
    logic                   outValid_q, outValid_d;
    logic [WIDTH-1:0]       outData_q, outData_d;
    logic                   ackToggle_q, ackToggle_d;

    // ------------------------------------------------------------------
    // A side
    // ------------------------------------------------------------------

    assign ackSynced     = ackSync_q[SYNC_STAGES-1];
    assign in_ready_clkA = (state_q == IDLE);
    assign busy_clkA     = ~in_ready_clkA;

    // Next-state logic for the A-side FSM. A word is accepted only in IDLE,
    // which is what keeps the hold register stable during the crossing.
    // The transfer is complete once the returned ack parity matches the
    // request parity, so toggle wrap-around needs no counter.
    always_comb begin
        state_d     = state_q;
        reqToggle_d = reqToggle_q;
        holdData_d  = holdData_q;
        case (state_q)
            IDLE: begin
                if (in_valid_clkA) begin
                    holdData_d  = in_data_clkA;
                    reqToggle_d = ~reqToggle_q;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ackSynced == reqToggle_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A-side registers, including the ack synchronizer chain.
    always_ff @(posedge clkA or posedge rstA) begin
        if (rstA) begin
            state_q     <= IDLE;
            reqToggle_q <= 1'b0;
            holdData_q  <= '0;
            ackSync_q   <= '0;
        end else begin
            state_q     <= state_d;
            reqToggle_q <= reqToggle_d;
            holdData_q  <= holdData_d;
            ackSync_q   <= {ackSync_q[SYNC_STAGES-2:0], ackToggle_q};
        end
    end

    // ------------------------------------------------------------------
    // B side
    // ------------------------------------------------------------------

    // A new request shows up as a parity change at the end of the sync chain.
    assign reqDetect      = reqSync_q[SYNC_STAGES-1] ^ reqEdge_q;
    assign out_valid_clkB = outValid_q;
    assign out_data_clkB  = outData_q;

    // Output register control. A request never arrives while a word is still
    // pending, because the A side waits for the ack that the handshake below
    // produces; the two branches are therefore mutually exclusive.
    always_comb begin
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        ackToggle_d = ackToggle_q;
        if (reqDetect) begin
            outData_d  = holdData_q;
            outValid_d = 1'b1;
        end else if (outValid_q && out_ready_clkB) begin
            outValid_d  = 1'b0;
            ackToggle_d = ~ackToggle_q;
        end
    end

    // B-side registers, including the request synchronizer and edge flop.
    always_ff @(posedge clkB or posedge rstB) begin
        if (rstB) begin
            reqSync_q   <= '0;
            reqEdge_q   <= 1'b0;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            ackToggle_q <= 1'b0;
        end else begin
            reqSync_q   <= {reqSync_q[SYNC_STAGES-2:0], reqToggle_q};
            reqEdge_q   <= reqSync_q[SYNC_STAGES-1];
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            ackToggle_q <= ackToggle_d;
        end
    end

endmodule

// File: tb/tb_data_ack_cross_domain.sv
// ---------------------------------------------------------------------------
// tb_data_ack_cross_domain
//
// Self-checking bench for data_ack_cross_domain. Accepted words are pushed
// into an expected-word queue and popped on every clkB handshake, so the
// delivered stream must match the accepted stream exactly, in order, once.
// Inputs change 1 ns after the active edge; monitors sample on the falling
// edge, predicting what the next rising edge will do.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_ack_cross_domain;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;

    logic             clkA, clkB, rstA, rstB;
    logic [WIDTH-1:0] inData;
    logic             inValid, inReady, busy;
    logic [WIDTH-1:0] outData;
    logic             outValid, outReady;

    real halfA = 5.0;      // 100 MHz
    real halfB = 13.5135;  // 37 MHz

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] expQ[$];
    int               acceptCount = 0;
    int               recvCount = 0;
    int               validHigh = 0;
    logic [WIDTH-1:0] lastRecv = '0;
    int               readyMode = 0;   // 0: always ready, 1: random, 2: stalled

    data_ack_cross_domain #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
        .clkA           (clkA),
        .rstA           (rstA),
        .clkB           (clkB),
        .rstB           (rstB),
        .in_data_clkA   (inData),
        .in_valid_clkA  (inValid),
        .in_ready_clkA  (inReady),
        .busy_clkA      (busy),
        .out_data_clkB  (outData),
        .out_valid_clkB (outValid),
        .out_ready_clkB (outReady)
    );

    initial clkA = 1'b0;
    initial clkB = 1'b0;
    always #(halfA) clkA = ~clkA;
    always #(halfB) clkB = ~clkB;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic stepA();
        @(posedge clkA);
        #1;
    endtask

    task automatic stepB();
        @(posedge clkB);
        #1;
    endtask

    // Offer a word and return right after the clkA edge that accepts it.
    // in_valid is left asserted; the caller decides what comes next.
    task automatic applyStimulus(input logic [WIDTH-1:0] d);
        int n;
        n = 0;
        inData  = d;
        inValid = 1'b1;
        while (!inReady && n < 2000) begin
            stepA();
            n++;
        end
        if (n >= 2000) checkOutput("accept_timeout", 1, 0);
        stepA();
    endtask

    // Wait until every accepted word is consumed and the source is idle again.
    task automatic waitIdle();
        int n;
        n = 0;
        while ((expQ.size() != 0 || !inReady) && n < 5000) begin
            stepA();
            n++;
        end
        if (n >= 5000) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic waitOutValid();
        int n;
        n = 0;
        while (!outValid && n < 500) begin
            stepB();
            n++;
        end
        if (n >= 500) checkOutput("out_valid_timeout", 1, 0);
    endtask

    // Assert both resets together, check the reset values while held.
    task automatic applyReset(input int cycles);
        rstA = 1'b1;
        rstB = 1'b1;
        expQ.delete();
        repeat (cycles) stepA();
        checkOutput("rst_in_ready", inReady, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", outValid, 0);
        checkOutput("rst_out_data", outData, 0);
        rstA = 1'b0;
        rstB = 1'b0;
        stepA();
    endtask

    // Consumer readiness, changed just after each clkB edge.
    always @(posedge clkB) begin
        #1;
        case (readyMode)
            0:       outReady = 1'b1;
            1:       outReady = 1'($urandom_range(1, 0));
            default: outReady = 1'b0;
        endcase
    end

    // Source-side monitor: an idle source must have nothing outstanding,
    // and a word offered while ready is taken on the next rising edge.
    always @(negedge clkA) begin
        if (!rstA) begin
            checkOutput("busy_is_not_ready", busy, !inReady);
            if (inReady) checkOutput("ready_with_word_in_flight", expQ.size(), 0);
            if (inValid && inReady) begin
                expQ.push_back(inData);
                acceptCount++;
            end
        end
    end

    // Destination-side monitor: each handshake must deliver the oldest
    // accepted word, and a new request may never meet a pending word.
    always @(negedge clkB) begin
        if (!rstB) begin
            checkOutput("no_req_while_valid", int'(dut.reqDetect & outValid), 0);
            if (outValid) validHigh++;
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_word", 1, 0);
                end else begin
                    checkOutput("out_data", outData, expQ.pop_front());
                end
                recvCount++;
                lastRecv = outData;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  n, lo, hi, base, acc0;
        real ta, tb;

        rstA = 1'b1;
        rstB = 1'b1;
        inData = '0;
        inValid = 1'b0;
        outReady = 1'b0;
        repeat (3) stepA();
        rstA = 1'b0;
        rstB = 1'b0;
        repeat (4) stepA();

        // Reset while idle
        applyReset(5);
        repeat (3) stepA();
        checkOutput("idle_in_ready", inReady, 1);
        checkOutput("idle_out_valid", outValid, 0);

        // Single word, consumer always ready
        $display("[TB] single word");
        readyMode = 0;
        validHigh = 0;
        base = recvCount;
        applyStimulus(8'hA5);
        inValid = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
        n = 0;
        while (busy && n < 200) begin
            n++;
            stepA();
        end
        ta = 2.0 * halfA;
        tb = 2.0 * halfB;
        lo = int'($ceil(((SYNC + 1) * tb + SYNC * ta) / ta)) - 1;
        hi = int'($floor(((SYNC + 2) * tb + (SYNC + 1) * ta) / ta)) + 1;
        if (n < lo || n > hi)
            $display("[TB] busy lasted %0d clkA cycles, allowed %0d..%0d", n, lo, hi);
        checkOutput("busy_latency_in_range", int'(n >= lo && n <= hi), 1);
        repeat (4) stepB();
        checkOutput("single_count", recvCount - base, 1);
        checkOutput("single_data", lastRecv, 8'hA5);
        checkOutput("single_valid_cycles", validHigh, 1);

        // Back-pressure with a second word waiting at the source
        $display("[TB] back-pressure");
        readyMode = 2;
        stepB();
        base = recvCount;
        applyStimulus(8'h3C);
        inData = 8'h77;
        acc0 = acceptCount;
        waitOutValid();
        for (int i = 0; i < 20; i++) begin
            stepB();
            checkOutput("bp_valid_held", outValid, 1);
            checkOutput("bp_data_held", outData, 8'h3C);
            checkOutput("bp_busy_held", busy, 1);
        end
        checkOutput("bp_no_accept", acceptCount - acc0, 0);
        readyMode = 0;
        applyStimulus(8'h77);
        inValid = 1'b0;
        waitIdle();
        checkOutput("bp_count", recvCount - base, 2);
        checkOutput("bp_last", lastRecv, 8'h77);

        // Bursts of 0x00..0xFF at two clock ratios with random back-pressure
        for (int pass = 0; pass < 2; pass++) begin
            $display("[TB] burst pass %0d", pass);
            if (pass == 1) begin
                halfA = 25.0;    // 20 MHz
                halfB = 3.3333;  // 150 MHz
                repeat (4) stepA();
            end
            readyMode = 1;
            base = recvCount;
            for (int w = 0; w < 256; w++) applyStimulus(WIDTH'(w));
            inValid = 1'b0;
            waitIdle();
            checkOutput("burst_count", recvCount - base, 256);
            checkOutput("burst_last", lastRecv, 8'hFF);
        end

        // Source data changes every cycle while the word is in flight
        $display("[TB] data stability");
        readyMode = 1;
        base = recvCount;
        applyStimulus(8'hC3);
        inValid = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            inData = WIDTH'($urandom);
            stepA();
            n++;
        end
        checkOutput("stable_count", recvCount - base, 1);
        checkOutput("stable_data", lastRecv, 8'hC3);

        // Reset while a word is waiting at the output
        $display("[TB] reset mid-transfer");
        readyMode = 2;
        stepB();
        applyStimulus(8'h99);
        inValid = 1'b0;
        waitOutValid();
        checkOutput("mid_valid_before_reset", outValid, 1);
        applyReset(3);
        readyMode = 0;
        base = recvCount;
        applyStimulus(8'h5A);
        inValid = 1'b0;
        waitIdle();
        repeat (20) stepA();
        checkOutput("post_reset_count", recvCount - base, 1);
        checkOutput("post_reset_data", lastRecv, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_ack_cross_domain.md
Name: data_ack_cross_domain

Overview:
- Moves a WIDTH-bit data word from the clkA domain to the clkB domain with a full round-trip acknowledge.
- Built on the team's toggle-flag crossing: a request toggle goes A→B, and an acknowledge toggle comes back B→A.
- Both sides use valid/ready handshakes. The clkB consumer may apply back-pressure, and the ack is returned only after it accepts the word.
- Sits between a clkA producer, e.g. a PMU sample/command source, and a clkB consumer. Exactly one word is in flight at a time.

Parameters:
- WIDTH, 8, data word width in bits.
- SYNC_STAGES, 2, synchronizer flops per crossing direction; legal values ≥2.

Ports:
- clkA  input  1  source clock
- rstA  input  1  source-domain reset, asynchronous, active-high
- clkB  input  1  destination clock
- rstB  input  1  destination-domain reset, asynchronous, active-high
- in_data_clkA  input  WIDTH  word to send
- in_valid_clkA  input  1  producer offers in_data_clkA
- in_ready_clkA  output  1  block can accept a word this clkA cycle
- busy_clkA  output  1  a word is in flight (equals ~in_ready_clkA)
- out_data_clkB  output  WIDTH  delivered word
- out_valid_clkB  output  1  out_data_clkB is valid
- out_ready_clkB  input  1  consumer accepts the word

Behaviour:
- Reset values:
  - rstA: in_ready_clkA=1, busy_clkA=0, req toggle=0, hold register=0, ack synchronizer=0, FSM=IDLE.
  - rstB: out_valid_clkB=0, out_data_clkB=0, ack toggle=0, req synchronizer=0, edge-detect flop=0.
- Reset usage: rstA and rstB are asserted together at system level. Asserting only one is unsupported; outputs still take their reset values, but a spurious or lost word is permitted.
- A-side FSM, states IDLE and WAIT_ACK:
  - IDLE: in_ready_clkA=1. On a clkA edge with in_valid_clkA=1, capture in_data_clkA into the hold register, invert the req toggle, and go to WAIT_ACK.
  - WAIT_ACK: in_ready_clkA=0 and in_valid_clkA is ignored. Return to IDLE on the first clkA edge where the synchronized ack (last ack sync stage) equals the req toggle.
- Hold register: changes only on acceptance in IDLE, so it is stable for the whole crossing. It is the only A-domain data path into clkB.
- B side, request detection:
  - The req toggle passes through SYNC_STAGES flops plus one edge-detect flop.
  - A request is detected when the last sync stage differs from the edge-detect flop.
  - On detection, load the hold register into out_data_clkB and set out_valid_clkB=1. The load occurs SYNC_STAGES+1 clkB edges after the toggle first reaches the synchronizer input.
- B side, output handshake:
  - While out_valid_clkB=1 and out_ready_clkB=0, hold out_valid_clkB and out_data_clkB unchanged for any duration.
  - On a clkB edge with out_valid_clkB=1 and out_ready_clkB=1, clear out_valid_clkB and invert the ack toggle.
  - out_data_clkB keeps its last value after acceptance.
- Ack return: the ack toggle passes through SYNC_STAGES clkA flops into the WAIT_ACK compare.
- Minimum round trip with out_ready_clkB held high:
  - SYNC_STAGES+1 clkB edges to out_valid_clkB.
  - +1 clkB edge for acceptance.
  - +SYNC_STAGES clkA edges, then +1 clkA edge to reach IDLE.
- No overflow path exists: a new request cannot be issued before the previous ack returns. Words are never dropped or duplicated.
- Simultaneous events on the B side: a new request cannot coincide with a pending out_valid_clkB, by construction. The bench asserts this never happens.
- Toggle parity handles wrap-around; no counters are used.
- Only the two 1-bit toggles cross through synchronizers. The multi-bit hold register is sampled by clkB only after the req toggle has been synchronized.

Test Plan:
- Reset: assert rstA/rstB for 5 cycles mid-idle → in_ready_clkA=1, busy_clkA=0, out_valid_clkB=0, out_data_clkB=0.
- Single word: WIDTH=8, SYNC_STAGES=2, clkA 100 MHz, clkB 37 MHz; send 0xA5 with out_ready_clkB=1 → out_valid_clkB high for exactly 1 clkB cycle with out_data_clkB=0xA5. busy_clkA returns 0 after the ack latency above, within ±1 clkA cycle.
- Back-pressure: send 0x3C with out_ready_clkB=0 for 20 clkB cycles, while in_valid_clkA stays 1 with data 0x77 → out_valid_clkB stays 1 and out_data_clkB stays 0x3C for all 20 cycles; busy_clkA stays 1 and 0x77 is not accepted. Release out_ready_clkB → 0x3C consumed, then 0x77 delivered next.
- Burst: continuous in_valid_clkA with data 0x00..0xFF; out_ready_clkB randomly 50% → exactly 256 words out, in order, no duplicates. Repeat with clkA 20 MHz and clkB 150 MHz.
- Data stability: during WAIT_ACK, change in_data_clkA every clkA cycle → out_data_clkB equals the value captured at acceptance.
- Reset mid-transfer: assert rstA and rstB together while out_valid_clkB=1 → all outputs reach reset values; the next word 0x5A is delivered correctly with no spurious word.
